// File: rtl/fetch_pc_unit_if.sv
// Fetch front-end bundle: NPC feedback, instruction-memory request/response and decode hand-off.
// The master modport is the fetch unit's view; slave is the surrounding pipeline/memory view.
interface fetch_pc_unit_if;
    logic [31:0] PC_In;
    logic        Redirect;
    logic [31:0] PCF;
    logic        IReq_Valid;
    logic [31:0] IReq_Addr;
    logic        IReq_Ready;
    logic        IResp_Valid;
    logic [31:0] IResp_Data;
    logic        InstrD_Valid;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic        InstrD_Ready;

    modport master (
        input  PC_In, Redirect, IReq_Ready, IResp_Valid, IResp_Data, InstrD_Ready,
        output PCF, IReq_Valid, IReq_Addr, InstrD_Valid, InstrD, PCD
    );

    modport slave (
        output PC_In, Redirect, IReq_Ready, IResp_Valid, IResp_Data, InstrD_Ready,
        input  PCF, IReq_Valid, IReq_Addr, InstrD_Valid, InstrD, PCD
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: holds PCF, issues credit-limited in-order fetches and buffers
// returned words with their PCs for decode; a redirect flushes the buffer and drops in-flight words.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input logic             CLK,
    input logic             RSTn,
    fetch_pc_unit_if.master bus
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam logic [PW-1:0] LAST = PW'(BUF_DEPTH - 1);

    logic [31:0]   pcf;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] buf_cnt;
    logic [PW-1:0] tag_wr;
    logic [PW-1:0] tag_rd;
    logic [PW-1:0] buf_wr;
    logic [PW-1:0] buf_rd;
    logic [31:0]   tag_mem  [BUF_DEPTH];
    logic [31:0]   pc_mem   [BUF_DEPTH];
    logic [31:0]   inst_mem [BUF_DEPTH];

    logic credit_ok;
    logic req_fire;
    logic resp_keep;
    logic dec_pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // Credits cover both outstanding and buffered words, so a kept response always has a slot.
    assign credit_ok = ({1'b0, out_cnt} + {1'b0, buf_cnt}) < (CW + 1)'(BUF_DEPTH);
    assign req_fire  = bus.IReq_Valid && bus.IReq_Ready;
    assign resp_keep = bus.IResp_Valid && !bus.Redirect && (drop_cnt == '0);
    assign dec_pop   = (buf_cnt != '0) && bus.InstrD_Ready && !bus.Redirect;

    assign bus.PCF          = pcf;
    assign bus.IReq_Addr    = pcf;
    assign bus.IReq_Valid   = RSTn && !bus.Redirect && credit_ok;
    assign bus.InstrD_Valid = (buf_cnt != '0);
    assign bus.InstrD       = inst_mem[buf_rd];
    assign bus.PCD          = pc_mem[buf_rd];

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pcf      <= RESET_PC;
            out_cnt  <= '0;
            drop_cnt <= '0;
            buf_cnt  <= '0;
            tag_wr   <= '0;
            tag_rd   <= '0;
            buf_wr   <= '0;
            buf_rd   <= '0;
        end else begin
            if (bus.Redirect || req_fire)
                pcf <= bus.PC_In;

            out_cnt <= out_cnt + CW'(req_fire) - CW'(bus.IResp_Valid);
            if (req_fire)
                tag_wr <= wrap_inc(tag_wr);
            if (bus.IResp_Valid)
                tag_rd <= wrap_inc(tag_rd);

            // A response landing in the redirect cycle is already gone, so it is not counted again.
            if (bus.Redirect)
                drop_cnt <= out_cnt - CW'(bus.IResp_Valid);
            else if (bus.IResp_Valid && (drop_cnt != '0))
                drop_cnt <= drop_cnt - CW'(1);

            if (bus.Redirect) begin
                buf_cnt <= '0;
                buf_wr  <= '0;
                buf_rd  <= '0;
            end else begin
                if (resp_keep)
                    buf_wr <= wrap_inc(buf_wr);
                if (dec_pop)
                    buf_rd <= wrap_inc(buf_rd);
                buf_cnt <= buf_cnt + CW'(resp_keep) - CW'(dec_pop);
            end
        end
    end

    // Storage needs no reset: the counters and pointers decide what is visible.
    always_ff @(posedge CLK) begin
        if (req_fire)
            tag_mem[tag_wr] <= pcf;
        if (resp_keep) begin
            pc_mem[buf_wr]   <= tag_mem[tag_rd];
            inst_mem[buf_wr] <= bus.IResp_Data;
        end
    end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus a randomized run, all checked
// against a queue-level model of requests in flight and instructions awaiting decode.
module tb_fetch_pc_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fetch_pc_unit_if bus ();

    fetch_pc_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
        .CLK (clk),
        .RSTn(rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: fetch PC, memory requests in flight (oldest first), PCs awaiting decode.
    logic [31:0] m_pc;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    bit          pend_stale[$];
    logic [31:0] exp_q[$];
    int          cyc;
    int          min_lat;
    int          max_lat;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic bit exp_req_valid();
        return !bus.Redirect && ((pend_addr.size() + exp_q.size()) < DEPTH);
    endfunction

    task automatic clear_model();
        m_pc = RST_PC;
        pend_addr.delete();
        pend_due.delete();
        pend_stale.delete();
        exp_q.delete();
        cyc = 0;
    endtask

    task automatic set_idle();
        bus.Redirect     = 1'b0;
        bus.PC_In        = '0;
        bus.IReq_Ready   = 1'b0;
        bus.IResp_Valid  = 1'b0;
        bus.IResp_Data   = '0;
        bus.InstrD_Ready = 1'b0;
    endtask

    // Called at a falling edge; leaves the bench at the falling edge that starts cycle 0.
    task automatic do_reset();
        rst_n = 1'b0;
        set_idle();
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives one cycle of inputs; memory answers the oldest request once its latency has elapsed.
    task automatic applyStimulus(input bit red, input logic [31:0] tgt, input bit rdy,
                                 input bit dready, input bit resp_en);
        bus.Redirect     = red;
        bus.PC_In        = red ? tgt : m_pc + 32'd4;
        bus.IReq_Ready   = rdy;
        bus.InstrD_Ready = dready;
        if (resp_en && (pend_addr.size() != 0) && (pend_due[0] <= cyc)) begin
            bus.IResp_Valid = 1'b1;
            bus.IResp_Data  = mem_word(pend_addr[0]);
        end else begin
            bus.IResp_Valid = 1'b0;
            bus.IResp_Data  = $urandom;
        end
        #1;
    endtask

    task automatic advance();
        bit          hs;
        bit          pop;
        bit          stale;
        logic [31:0] a;
        hs    = exp_req_valid() && bus.IReq_Ready;
        pop   = (exp_q.size() != 0) && bus.InstrD_Ready;
        stale = 1'b1;
        a     = '0;
        if (bus.IResp_Valid) begin
            a     = pend_addr.pop_front();
            stale = pend_stale.pop_front();
            void'(pend_due.pop_front());
        end
        if (bus.Redirect) begin
            exp_q.delete();
            foreach (pend_stale[i]) pend_stale[i] = 1'b1;
            m_pc = bus.PC_In;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (bus.IResp_Valid && !stale) exp_q.push_back(a);
            if (hs) begin
                pend_addr.push_back(m_pc);
                pend_due.push_back(cyc + int'($urandom_range(max_lat, min_lat)));
                pend_stale.push_back(1'b0);
                m_pc = bus.PC_In;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_idle();
        clear_model();
        repeat (2) @(negedge clk);
        checks++; if (bus.PCF !== RST_PC) begin errors++; $display("[TB] FAIL reset_pcf got %h exp %h", bus.PCF, RST_PC); end
        checks++; if (bus.IReq_Valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_ireq_valid got %b exp 0", bus.IReq_Valid); end
        checks++; if (bus.InstrD_Valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_instrd_valid got %b exp 0", bus.InstrD_Valid); end
        rst_n = 1'b1;
        min_lat = 1; max_lat = 1;
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
        checks++; if (bus.IReq_Valid !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ireq_valid got %b exp 1", bus.IReq_Valid); end
        checks++; if (bus.IReq_Addr !== RST_PC) begin errors++; $display("[TB] FAIL post_reset_addr got %h exp %h", bus.IReq_Addr, RST_PC); end
        advance();
    endtask

    task automatic test_reset_fetch();
        logic [31:0] got[$];
        do_reset();
        min_lat = 1; max_lat = 1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
            checks++; if (bus.InstrD_Valid !== (exp_q.size() != 0)) begin errors++; $display("[TB] FAIL fetch_valid cyc %0d got %b exp %b", cyc, bus.InstrD_Valid, exp_q.size() != 0); end
            if (exp_q.size() != 0) begin
                checks++; if (bus.PCD !== exp_q[0]) begin errors++; $display("[TB] FAIL fetch_pcd cyc %0d got %h exp %h", cyc, bus.PCD, exp_q[0]); end
                checks++; if (bus.InstrD !== mem_word(exp_q[0])) begin errors++; $display("[TB] FAIL fetch_instr cyc %0d got %h exp %h", cyc, bus.InstrD, mem_word(exp_q[0])); end
            end
            if (bus.InstrD_Valid === 1'b1) got.push_back(bus.PCD);
            advance();
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ((got.size() <= i) || (got[i] !== RST_PC + 32'(4 * i))) begin
                errors++; $display("[TB] FAIL fetch_order idx %0d got %h exp %h", i, (got.size() > i) ? got[i] : 32'hx, RST_PC + 32'(4 * i));
            end
        end
    endtask

    task automatic test_credit_limit();
        logic [31:0] addrs[$];
        int          n_new;
        do_reset();
        min_lat = 1; max_lat = 1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
            checks++; if (bus.IReq_Valid !== exp_req_valid()) begin errors++; $display("[TB] FAIL credit_valid cyc %0d got %b exp %b", cyc, bus.IReq_Valid, exp_req_valid()); end
            if (bus.IReq_Valid === 1'b1) addrs.push_back(bus.IReq_Addr);
            advance();
        end
        checks++; if (addrs.size() != 2) begin errors++; $display("[TB] FAIL credit_count got %0d exp 2", addrs.size()); end
        checks++; if ((addrs.size() < 2) || (addrs[0] !== RST_PC) || (addrs[1] !== RST_PC + 32'd4)) begin errors++; $display("[TB] FAIL credit_addrs got %0d entries exp %h,%h", addrs.size(), RST_PC, RST_PC + 32'd4); end
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
        checks++; if (bus.IReq_Valid !== 1'b0) begin errors++; $display("[TB] FAIL credit_full_valid got %b exp 0", bus.IReq_Valid); end
        checks++; if (bus.PCD !== RST_PC) begin errors++; $display("[TB] FAIL credit_pop_pcd got %h exp %h", bus.PCD, RST_PC); end
        advance();
        n_new = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
            if (bus.IReq_Valid === 1'b1) begin
                n_new++;
                checks++; if (bus.IReq_Addr !== RST_PC + 32'd8) begin errors++; $display("[TB] FAIL credit_new_addr got %h exp %h", bus.IReq_Addr, RST_PC + 32'd8); end
            end
            advance();
        end
        checks++; if (n_new != 1) begin errors++; $display("[TB] FAIL credit_new_count got %0d exp 1", n_new); end
    endtask

    task automatic test_redirect_inflight();
        bit          seen_req;
        bit          seen_dec;
        logic [31:0] first_addr;
        logic [31:0] first_pcd;
        do_reset();
        min_lat = 3; max_lat = 3;
        repeat (2) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
            advance();
        end
        applyStimulus(1'b1, 32'h0000_0100, 1'b1, 1'b1, 1'b1);
        checks++; if (bus.IReq_Valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_valid got %b exp 0", bus.IReq_Valid); end
        advance();
        checks++; if (bus.PCF !== 32'h0000_0100) begin errors++; $display("[TB] FAIL redir_pcf got %h exp 00000100", bus.PCF); end
        seen_req = 1'b0; seen_dec = 1'b0; first_addr = '0; first_pcd = '0;
        for (int i = 0; (i < 20) && !seen_dec; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
            if (!seen_req && (bus.IReq_Valid === 1'b1)) begin seen_req = 1'b1; first_addr = bus.IReq_Addr; end
            if (bus.InstrD_Valid === 1'b1) begin seen_dec = 1'b1; first_pcd = bus.PCD; end
            advance();
        end
        checks++; if (!seen_req || (first_addr !== 32'h0000_0100)) begin errors++; $display("[TB] FAIL redir_first_req seen %b got %h exp 00000100", seen_req, first_addr); end
        checks++; if (!seen_dec || (first_pcd !== 32'h0000_0100)) begin errors++; $display("[TB] FAIL redir_first_pcd seen %b got %h exp 00000100", seen_dec, first_pcd); end
    endtask

    task automatic test_simultaneous();
        bit          seen_dec;
        logic [31:0] first_pcd;
        logic [31:0] first_ins;
        do_reset();
        min_lat = 1; max_lat = 1;
        repeat (2) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
            advance();
        end
        applyStimulus(1'b1, 32'h0000_2000, 1'b1, 1'b1, 1'b1);
        checks++; if (bus.InstrD_Valid !== 1'b1) begin errors++; $display("[TB] FAIL simul_pre_valid got %b exp 1", bus.InstrD_Valid); end
        advance();
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
        checks++; if (bus.InstrD_Valid !== 1'b0) begin errors++; $display("[TB] FAIL simul_flush got %b exp 0", bus.InstrD_Valid); end
        checks++; if (bus.IReq_Valid !== 1'b1) begin errors++; $display("[TB] FAIL simul_req_valid got %b exp 1", bus.IReq_Valid); end
        checks++; if (bus.IReq_Addr !== 32'h0000_2000) begin errors++; $display("[TB] FAIL simul_req_addr got %h exp 00002000", bus.IReq_Addr); end
        seen_dec = 1'b0; first_pcd = '0; first_ins = '0;
        for (int i = 0; (i < 10) && !seen_dec; i++) begin
            if (i != 0) applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
            if (bus.InstrD_Valid === 1'b1) begin seen_dec = 1'b1; first_pcd = bus.PCD; first_ins = bus.InstrD; end
            advance();
        end
        checks++; if (!seen_dec || (first_pcd !== 32'h0000_2000) || (first_ins !== mem_word(32'h0000_2000))) begin
            errors++; $display("[TB] FAIL simul_first seen %b pcd %h ins %h exp pcd 00002000 ins %h", seen_dec, first_pcd, first_ins, mem_word(32'h0000_2000));
        end
    endtask

    task automatic test_backpressure();
        bit          rdy_pat[5];
        logic [31:0] exp_addr[5];
        rdy_pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_addr = '{RST_PC, RST_PC + 32'd4, RST_PC + 32'd4, RST_PC + 32'd4, RST_PC + 32'd8};
        do_reset();
        min_lat = 1; max_lat = 1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, '0, rdy_pat[i], 1'b1, 1'b1);
            checks++; if (bus.IReq_Addr !== exp_addr[i]) begin errors++; $display("[TB] FAIL bp_addr step %0d got %h exp %h", i, bus.IReq_Addr, exp_addr[i]); end
            checks++; if (bus.PCF !== exp_addr[i]) begin errors++; $display("[TB] FAIL bp_pcf step %0d got %h exp %h", i, bus.PCF, exp_addr[i]); end
            checks++; if (bus.IReq_Valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid step %0d got %b exp 1", i, bus.IReq_Valid); end
            advance();
        end
    endtask

    task automatic test_midrun_reset();
        bit          seen_req;
        bit          seen_dec;
        logic [31:0] first_addr;
        logic [31:0] first_pcd;
        do_reset();
        min_lat = 2; max_lat = 2;
        repeat (3) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
            advance();
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.InstrD_Valid !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre_valid got %b exp 1", bus.InstrD_Valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.InstrD_Valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_instrd_valid got %b exp 0", bus.InstrD_Valid); end
        checks++; if (bus.PCF !== RST_PC) begin errors++; $display("[TB] FAIL midrst_pcf got %h exp %h", bus.PCF, RST_PC); end
        checks++; if (bus.IReq_Valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ireq_valid got %b exp 0", bus.IReq_Valid); end
        set_idle();
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        seen_req = 1'b0; seen_dec = 1'b0; first_addr = '0; first_pcd = '0;
        for (int i = 0; (i < 12) && !seen_dec; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
            if (!seen_req && (bus.IReq_Valid === 1'b1)) begin seen_req = 1'b1; first_addr = bus.IReq_Addr; end
            if (bus.InstrD_Valid === 1'b1) begin seen_dec = 1'b1; first_pcd = bus.PCD; end
            advance();
        end
        checks++; if (!seen_req || (first_addr !== RST_PC)) begin errors++; $display("[TB] FAIL midrst_restart_addr seen %b got %h exp %h", seen_req, first_addr, RST_PC); end
        checks++; if (!seen_dec || (first_pcd !== RST_PC)) begin errors++; $display("[TB] FAIL midrst_first_pcd seen %b got %h exp %h", seen_dec, first_pcd, RST_PC); end
    endtask

    task automatic test_random();
        bit          red;
        logic [31:0] tgt;
        do_reset();
        min_lat = 1; max_lat = 3;
        for (int i = 0; i < 1500; i++) begin
            red = ($urandom_range(99, 0) < 8);
            tgt = $urandom & 32'hFFFF_FFFC;
            applyStimulus(red, tgt, $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0, $urandom_range(4, 0) != 0);
            checks++; if (bus.IReq_Valid !== exp_req_valid()) begin errors++; $display("[TB] FAIL rnd_req_valid cyc %0d got %b exp %b", cyc, bus.IReq_Valid, exp_req_valid()); end
            checks++; if (bus.IReq_Addr !== m_pc) begin errors++; $display("[TB] FAIL rnd_req_addr cyc %0d got %h exp %h", cyc, bus.IReq_Addr, m_pc); end
            checks++; if (bus.PCF !== m_pc) begin errors++; $display("[TB] FAIL rnd_pcf cyc %0d got %h exp %h", cyc, bus.PCF, m_pc); end
            checks++; if (bus.InstrD_Valid !== (exp_q.size() != 0)) begin errors++; $display("[TB] FAIL rnd_instrd_valid cyc %0d got %b exp %b", cyc, bus.InstrD_Valid, exp_q.size() != 0); end
            if (exp_q.size() != 0) begin
                checks++; if (bus.PCD !== exp_q[0]) begin errors++; $display("[TB] FAIL rnd_pcd cyc %0d got %h exp %h", cyc, bus.PCD, exp_q[0]); end
                checks++; if (bus.InstrD !== mem_word(exp_q[0])) begin errors++; $display("[TB] FAIL rnd_instrd cyc %0d got %h exp %h", cyc, bus.InstrD, mem_word(exp_q[0])); end
            end
            advance();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        set_idle();
        clear_model();
        min_lat = 1;
        max_lat = 1;
        @(negedge clk);
        $display("[TB] starting fetch_pc_unit tests");
        test_reset();
        test_reset_fetch();
        test_credit_limit();
        test_redirect_inflight();
        test_simultaneous();
        test_backpressure();
        test_midrun_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
